// File: rtl/column_scheduler_pkg.sv
// Shared types for the column scheduler: FSM states, ray-result payload, column word width.
package column_scheduler_pkg;

  localparam int unsigned COL_W = 12;
  localparam int unsigned X_W   = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic [3:0] shade;
    logic [7:0] half_h;
  } col_rsp_t;

endpackage

// File: rtl/col_bank.sv
// One column bank: simple dual-port RAM, one write port and one registered read port.
module col_bank
  import column_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH = 480,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  col_rsp_t      wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output col_rsp_t      rdata
);

  col_rsp_t mem [DEPTH];

  // Storage is deliberately not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A disabled read returns zero so out-of-view pixels are black.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end else begin
      rdata <= '0;
    end
  end

endmodule

// File: rtl/column_scheduler.sv
// Requests one ray per 3-D view column per frame into a back bank and double-buffers it for display.
// Optional macro FRAME_STATS_EN enables the missed-swap counter on frame_drops.
module column_scheduler
  import column_scheduler_pkg::*;
#(
  parameter int unsigned NUM_COLS   = 480,
  parameter int unsigned COL_OFFSET = 160
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             vsync_pulse,
  input  logic [X_W-1:0]   DrawX,
  output logic             req_valid,
  output logic [X_W-1:0]   req_col,
  input  logic             req_ready,
  input  logic             rsp_valid,
  input  logic [COL_W-1:0] rsp_data,
  output logic [COL_W-1:0] memdata,
  output logic             frame_ready,
  output logic [7:0]       frame_drops
);

  localparam int unsigned  AW       = $clog2(NUM_COLS);
  localparam logic [X_W-1:0] LAST_COL = X_W'(NUM_COLS - 1);

  sched_state_t   state;
  logic [X_W-1:0] col;
  logic           bank_sel;
  logic           rd_sel_q;

  logic           wr_en_c;
  logic           in_range_c;
  logic [AW-1:0]  rd_addr_c;
  col_rsp_t       rsp_word_c;
  col_rsp_t       rdata0;
  col_rsp_t       rdata1;

  assign wr_en_c    = (state == WAIT) && rsp_valid;
  assign rsp_word_c = col_rsp_t'(rsp_data);
  assign in_range_c = (32'(DrawX) >= COL_OFFSET) && (32'(DrawX) < COL_OFFSET + NUM_COLS);
  assign rd_addr_c  = AW'(DrawX - X_W'(COL_OFFSET));

  // Scheduler FSM; all outputs are registered alongside the state.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      col         <= '0;
      bank_sel    <= 1'b0;
      req_valid   <= 1'b0;
      req_col     <= '0;
      frame_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vsync_pulse) begin
            col       <= '0;
            req_col   <= '0;
            req_valid <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (req_valid && req_ready) begin
            req_valid <= 1'b0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (rsp_valid) begin
            if (col == LAST_COL) begin
              frame_ready <= 1'b1;
              state       <= DONE;
            end else begin
              col       <= col + X_W'(1);
              req_col   <= col + X_W'(1);
              req_valid <= 1'b1;
              state     <= ISSUE;
            end
          end
        end
        DONE: begin
          if (vsync_pulse) begin
            bank_sel    <= ~bank_sel;
            col         <= '0;
            req_col     <= '0;
            req_valid   <= 1'b1;
            frame_ready <= 1'b0;
            state       <= ISSUE;
          end
        end
        default: begin
          state     <= IDLE;
          req_valid <= 1'b0;
        end
      endcase
    end
  end

  // Bank select for the read data, captured on the same edge as the read itself.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_sel_q <= 1'b0;
    end else begin
      rd_sel_q <= bank_sel;
    end
  end

  // The back bank is the one not selected by bank_sel.
  col_bank #(.DEPTH(NUM_COLS), .AW(AW)) u_bank0 (
    .clk   (Clk),
    .rst   (Reset),
    .we    (wr_en_c && bank_sel),
    .waddr (AW'(col)),
    .wdata (rsp_word_c),
    .re    (in_range_c),
    .raddr (rd_addr_c),
    .rdata (rdata0)
  );

  col_bank #(.DEPTH(NUM_COLS), .AW(AW)) u_bank1 (
    .clk   (Clk),
    .rst   (Reset),
    .we    (wr_en_c && !bank_sel),
    .waddr (AW'(col)),
    .wdata (rsp_word_c),
    .re    (in_range_c),
    .raddr (rd_addr_c),
    .rdata (rdata1)
  );

  // memdata is the front bank's read register; both inputs to this mux are flops.
  assign memdata = rd_sel_q ? COL_W'(rdata1) : COL_W'(rdata0);

`ifdef FRAME_STATS_EN
  logic [7:0] drops_q;

  // A frame boundary arriving before the back bank is complete is a missed swap.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      drops_q <= '0;
    end else if (vsync_pulse && ((state == ISSUE) || (state == WAIT)) && (drops_q != 8'hFF)) begin
      drops_q <= drops_q + 8'd1;
    end
  end

  assign frame_drops = drops_q;
`else
  assign frame_drops = '0;
`endif

endmodule

// File: tb/tb_column_scheduler.sv
// Directed bench for column_scheduler: frame fill, swap, display read, drops, stall, strays, reset.
module tb_column_scheduler;

`ifdef FRAME_STATS_EN
  localparam int EXP_DROP = 1;
`else
  localparam int EXP_DROP = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset;
  logic        vsync_pulse;
  logic [9:0]  DrawX;
  logic        req_valid;
  logic [9:0]  req_col;
  logic        req_ready;
  logic        rsp_valid;
  logic [11:0] rsp_data;
  logic [11:0] memdata;
  logic        frame_ready;
  logic [7:0]  frame_drops;

  int tests = 0;
  int fails = 0;

  column_scheduler #(.NUM_COLS(480), .COL_OFFSET(160)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .vsync_pulse (vsync_pulse),
    .DrawX       (DrawX),
    .req_valid   (req_valid),
    .req_col     (req_col),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .memdata     (memdata),
    .frame_ready (frame_ready),
    .frame_drops (frame_drops)
  );

  always #5 Clk = ~Clk;

  function automatic logic [11:0] fa(input int c);
    return 12'(c * 5 + 291);
  endfunction

  function automatic logic [11:0] fb(input int c);
    return (c == 5) ? 12'hA3C : 12'(c * 3 + 2048);
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (req_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  // Ray engine model: ready high, result two cycles after the accept edge.
  task automatic serve(input int c, input logic [11:0] d);
    wait_req();
    chk("req_valid", 32'(req_valid), 32'd1);
    chk("req_col", 32'(req_col), 32'(c));
    tick();
    tick();
    rsp_valid = 1'b1;
    rsp_data  = d;
    tick();
    rsp_valid = 1'b0;
    rsp_data  = '0;
  endtask

  task automatic rd(input string tag, input int x, input logic [11:0] exp);
    DrawX = 10'(x);
    tick();
    chk(tag, 32'(memdata), 32'(exp));
  endtask

  initial begin
    Reset       = 1'b1;
    vsync_pulse = 1'b0;
    DrawX       = '0;
    req_ready   = 1'b1;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    tick();
    tick();
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_col", 32'(req_col), 32'd0);
    chk("rst_memdata", 32'(memdata), 32'd0);
    chk("rst_frame_ready", 32'(frame_ready), 32'd0);
    chk("rst_frame_drops", 32'(frame_drops), 32'd0);
    Reset = 1'b0;
    tick();
    tick();
    chk("idle_no_req", 32'(req_valid), 32'd0);

    // Frame A; first request follows vsync by one cycle
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("vs_req_valid", 32'(req_valid), 32'd1);
    chk("vs_req_col", 32'(req_col), 32'd0);
    for (int c = 0; c < 200; c++) serve(c, fa(c));

    // Early vsync while waiting on column 200
    wait_req();
    chk("c200_req_col", 32'(req_col), 32'd200);
    tick();
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("drop_count", 32'(frame_drops), 32'(EXP_DROP));
    chk("drop_still_wait", 32'(req_valid), 32'd0);
    chk("drop_no_ready", 32'(frame_ready), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = fa(200);
    tick();
    rsp_valid = 1'b0;
    for (int c = 201; c < 300; c++) serve(c, fa(c));

    // Backpressure at column 300 with a stray response while in ISSUE
    wait_req();
    req_ready = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 12'hFFF;
    tick();
    rsp_valid = 1'b0;
    chk("stray_issue_hold", {21'd0, req_valid, req_col}, {21'd0, 1'b1, 10'd300});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_stable", {21'd0, req_valid, req_col}, {21'd0, 1'b1, 10'd300});
    end
    req_ready = 1'b1;
    for (int c = 300; c < 480; c++) serve(c, fa(c));

    chk("a_frame_ready", 32'(frame_ready), 32'd1);
    chk("a_done_no_req", 32'(req_valid), 32'd0);
    rsp_valid = 1'b1;
    rsp_data  = 12'hFFF;
    tick();
    rsp_valid = 1'b0;
    tick();
    chk("a_done_hold", 32'(frame_ready), 32'd1);

    // Swap to frame A, hold the next fill at column 0 while reading
    req_ready   = 1'b0;
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("swap_req_valid", 32'(req_valid), 32'd1);
    chk("swap_req_col", 32'(req_col), 32'd0);
    chk("swap_ready_clr", 32'(frame_ready), 32'd0);
    chk("swap_drops_hold", 32'(frame_drops), 32'(EXP_DROP));
    rd("rdA_165", 165, fa(5));
    rd("rdA_160", 160, fa(0));
    rd("rdA_360", 360, fa(200));
    rd("rdA_460", 460, fa(300));
    rd("rdA_639", 639, fa(479));
    rd("rdA_100", 100, 12'h000);
    rd("rdA_159", 159, 12'h000);
    rd("rdA_640", 640, 12'h000);

    // Frame B with column 5 = A3C
    req_ready = 1'b1;
    for (int c = 0; c < 480; c++) serve(c, fb(c));
    chk("b_frame_ready", 32'(frame_ready), 32'd1);
    rd("preswap_165", 165, fa(5));
    req_ready   = 1'b0;
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("swap_edge_old", 32'(memdata), 32'(fa(5)));
    tick();
    chk("postswap_165", 32'(memdata), 32'h0A3C);
    rd("rdB_100", 100, 12'h000);
    rd("rdB_170", 170, fb(10));

    // Reset during WAIT, then a late response
    req_ready = 1'b1;
    wait_req();
    chk("c_req_col", 32'(req_col), 32'd0);
    tick();
    Reset = 1'b1;
    #1;
    chk("rstwait_req_valid", 32'(req_valid), 32'd0);
    chk("rstwait_memdata", 32'(memdata), 32'd0);
    tick();
    Reset     = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 12'hEEE;
    tick();
    rsp_valid = 1'b0;
    tick();
    tick();
    chk("late_rsp_idle", 32'(req_valid), 32'd0);
    chk("late_rsp_ready", 32'(frame_ready), 32'd0);
    chk("late_rsp_drops", 32'(frame_drops), 32'd0);
    rd("keep_bank_165", 165, 12'hA3C);
    vsync_pulse = 1'b1;
    tick();
    vsync_pulse = 1'b0;
    chk("restart_valid", 32'(req_valid), 32'd1);
    chk("restart_col", 32'(req_col), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
